clock_monitor: RTL

CLOCK_MONITOR -- requirements
Module: clock_monitor

---
 rtl/clock_monitor.sv | 92 +++++++++
 1 files changed

// File: rtl/clock_monitor.sv
// clock_monitor: measures period and high time of sig_in, flags tolerance errors, lock and stall
module clock_monitor #(
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 1000,
  parameter int EXP_PERIOD = 10,
  parameter int TOL        = 1,
  parameter int LOCK_N     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             stalled,
  output logic             err
);
  localparam int MW = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] EP  = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] TL  = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [MW-1:0]    LN  = MW'(LOCK_N);
  localparam logic [MW-1:0]    LN1 = MW'(LOCK_N - 1);
  typedef enum logic {IDLE, MEASURE} state_t;
  state_t state, state_nx;
  logic s1, s2, s3, rise, fall, hi_done, start, sample, stall, in_tol;
  logic [CNT_W-1:0] cyc_cnt, hi_cnt, diff;
  logic [MW-1:0] match;
  always_ff @(posedge clk)
    if (reset) {s1, s2, s3} <= 3'b000;
    else {s1, s2, s3} <= {sig_in, s1, s2};
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb
    state_nx = (state == IDLE) ? (rise ? MEASURE : IDLE) : (stall ? IDLE : MEASURE);
  // a rise in the timeout cycle takes priority, so stall requires no rise
  always_comb begin
    start  = (state == IDLE) && rise;
    sample = (state == MEASURE) && rise;
    stall  = (state == MEASURE) && !rise && (cyc_cnt == TO);
  end
  always_comb begin
    diff   = (cyc_cnt > EP) ? cyc_cnt - EP : EP - cyc_cnt;
    in_tol = diff <= TL;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt   <= '0;
      hi_cnt    <= '0;
      hi_done   <= 1'b0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
      locked    <= 1'b0;
      stalled   <= 1'b0;
      match     <= '0;
    end else begin
      valid <= sample;
      err   <= sample && !in_tol;
      if (start || sample) begin
        cyc_cnt <= ONE;
        hi_cnt  <= ONE;
        hi_done <= 1'b0;
      end else if (state == IDLE || stall) begin
        cyc_cnt <= '0;
        hi_cnt  <= '0;
        hi_done <= 1'b0;
      end else begin
        cyc_cnt <= cyc_cnt + ONE;
        hi_cnt  <= (hi_done || fall) ? hi_cnt : hi_cnt + ONE;
        hi_done <= hi_done || fall;
      end
      if (sample) begin
        period    <= cyc_cnt;
        high_time <= hi_cnt;
        match     <= !in_tol ? '0 : (match == LN) ? match : match + MW'(1);
        locked    <= in_tol && (locked || match >= LN1);
      end
      if (stall) begin
        stalled <= 1'b1;
        locked  <= 1'b0;
        match   <= '0;
      end
      if (start) stalled <= 1'b0;
    end
  end
endmodule
